// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data window, optional parity, stop bits.
// Optional completed-frame counter is built only when UART_TX_FRAME_CNT_EN is defined.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Data_Valid,
    input  logic        PAR_EN,
    input  logic        ser_done,
    output logic        ser_en,
    output logic [1:0]  mux_sel,
    output logic        busy,
    output logic        err,
    output logic [15:0] frame_cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam logic [BW-1:0] WD_LIMIT  = BW'(DATA_WIDTH + 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_STOP   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          par_en_q, par_en_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]    stop_cnt_q, stop_cnt_d;
    logic          err_q, err_d;
    logic          ser_en_q, ser_en_d;
    logic [1:0]    mux_sel_q, mux_sel_d;
    logic          busy_q, busy_d;

    // Data_Valid is a level request: it is taken on any edge where the FSM sits in
    // IDLE and is dropped (not queued) while a frame is in flight.
    always_comb begin
        state_d    = state_q;
        par_en_d   = par_en_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    err_d     = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (ser_done) begin
                    state_d    = par_en_q ? PARITY : STOP;
                    stop_cnt_d = '0;
                end else if (bit_cnt_d == WD_LIMIT) begin
                    // Serializer never reported its last bit: abandon the frame.
                    state_d    = STOP;
                    err_d      = 1'b1;
                    stop_cnt_d = '0;
                end
            end
            PARITY: begin
                state_d    = STOP;
                stop_cnt_d = '0;
            end
            STOP: begin
                if (stop_cnt_q == STOP_LAST) begin
                    state_d = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        ser_en_d  = 1'b0;
        mux_sel_d = MUX_STOP;
        busy_d    = 1'b0;
        case (state_d)
            START: begin
                ser_en_d  = 1'b1;
                mux_sel_d = MUX_START;
                busy_d    = 1'b1;
            end
            DATA: begin
                ser_en_d  = 1'b1;
                mux_sel_d = MUX_DATA;
                busy_d    = 1'b1;
            end
            PARITY: begin
                mux_sel_d = MUX_PARITY;
                busy_d    = 1'b1;
            end
            STOP: begin
                mux_sel_d = MUX_STOP;
                busy_d    = 1'b1;
            end
            default: begin
                ser_en_d  = 1'b0;
                mux_sel_d = MUX_STOP;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            par_en_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            err_q      <= 1'b0;
            ser_en_q   <= 1'b0;
            mux_sel_q  <= MUX_STOP;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            par_en_q   <= par_en_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            err_q      <= err_d;
            ser_en_q   <= ser_en_d;
            mux_sel_q  <= mux_sel_d;
            busy_q     <= busy_d;
        end
    end

    assign ser_en  = ser_en_q;
    assign mux_sel = mux_sel_q;
    assign busy    = busy_q;
    assign err     = err_q;

`ifdef UART_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // A frame that tripped the watchdog still carries err_q through STOP, so it is not counted.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == STOP && stop_cnt_q == STOP_LAST && !err_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_cnt_q <= 16'h0000;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: expected frame traces are queued by the stimulus and
// checked by a monitor each time busy falls at the end of a frame.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
    localparam int W  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic        par_en;
    logic        ser_done;
    logic        ser_en;
    logic [1:0]  mux_sel;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;

    logic        sd_normal;
    int          dcnt;

    logic [W-1:0] exp_q[$];
    int           gap_of[$];
    int           tests = 0;
    int           fails = 0;
    int           frames_done = 0;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
        .CLK       (clk),
        .RST       (rst),
        .Data_Valid(dv),
        .PAR_EN    (par_en),
        .ser_done  (ser_done),
        .ser_en    (ser_en),
        .mux_sel   (mux_sel),
        .busy      (busy),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // Serializer model: flags the last data bit during the DW-th DATA cycle.
    always_ff @(posedge clk) begin
        if (mux_sel == 2'b10) dcnt <= dcnt + 1;
        else                  dcnt <= 0;
    end
    assign ser_done = sd_normal && (mux_sel == 2'b10) && (dcnt == DW - 1);

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fc_exp(input int n);
`ifdef UART_TX_FRAME_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    // Packs {ser_en trace[12], mux_sel trace[24], length[4], err at end, frame_cnt at end}.
    function automatic logic [W-1:0] mk_exp(input int nd, input bit par, input bit e,
                                            input logic [15:0] fc);
        logic [23:0] mt;
        logic [11:0] st;
        int          n;
        mt = {22'd0, 2'b00};
        st = {11'd0, 1'b1};
        n  = 1;
        for (int i = 0; i < nd; i++) begin
            mt = {mt[21:0], 2'b10};
            st = {st[10:0], 1'b1};
            n++;
        end
        if (par) begin
            mt = {mt[21:0], 2'b11};
            st = {st[10:0], 1'b0};
            n++;
        end
        mt = {mt[21:0], 2'b01};
        st = {st[10:0], 1'b0};
        n++;
        return {7'd0, st, mt, 4'(n), e, fc};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        busy_prev;
        logic [23:0] mux_tr;
        logic [11:0] se_tr;
        int          len;
        int          idle_cnt;
        logic [W-1:0] e;
        busy_prev = 1'b0;
        mux_tr    = '0;
        se_tr     = '0;
        len       = 0;
        idle_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                mux_tr    = '0;
                se_tr     = '0;
                len       = 0;
                idle_cnt  = 0;
            end else if (busy) begin
                if (!busy_prev) gap_of.push_back(idle_cnt);
                mux_tr    = {mux_tr[21:0], mux_sel};
                se_tr     = {se_tr[10:0], ser_en};
                len++;
                busy_prev = 1'b1;
            end else begin
                if (busy_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_len",     32'(len),    32'(e[20:17]));
                        check("mux_sel_trace", 32'(mux_tr), 32'(e[44:21]));
                        check("ser_en_trace",  32'(se_tr),  32'(e[56:45]));
                        check("err_at_end",    32'(err),    32'(e[16]));
                        check("frame_cnt",     32'(frame_cnt), 32'(e[15:0]));
                    end
                    frames_done++;
                    mux_tr   = '0;
                    se_tr    = '0;
                    len      = 0;
                    idle_cnt = 0;
                end
                idle_cnt++;
                busy_prev = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_dv(input bit p);
        dv     = 1'b1;
        par_en = p;
        tick(1);
        dv     = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 200) begin
            tick(1);
            t++;
        end
        check("frame_done_wait", 32'(frames_done), 32'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ser_en"},  32'(ser_en),  32'd0);
        check({tag, "_mux_sel"}, 32'(mux_sel), 32'd1);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        dv        = 1'b0;
        par_en    = 1'b0;
        sd_normal = 1'b1;
        tick(2);
        check_idle_outputs("reset");
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick(1);

        // Reset in the middle of the data window.
        pulse_dv(1'b0);
        tick(3);
        check("pre_reset_mux_data", 32'(mux_sel), 32'd2);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check_idle_outputs("rst_held");
        end
        rst = 1'b0;
        tick(1);
        check_idle_outputs("rst_released");
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick(2);

        // Plain frame, no parity: 00, 10 x8, 01.
        exp_q.push_back(mk_exp(DW, 1'b0, 1'b0, fc_exp(1)));
        pulse_dv(1'b0);
        wait_frames(1);
        tick(2);

        // Parity frame with PAR_EN dropped mid-frame, plus a request while busy.
        exp_q.push_back(mk_exp(DW, 1'b1, 1'b0, fc_exp(2)));
        pulse_dv(1'b1);
        tick(3);
        par_en = 1'b0;
        dv     = 1'b1;
        tick(1);
        dv     = 1'b0;
        wait_frames(2);
        tick(5);
        check("busy_req_ignored", 32'(busy), 32'd0);
        check("busy_req_no_extra_frame", 32'(exp_q.size()), 32'd0);

        // Data_Valid held high: three frames back to back.
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_exp(DW, 1'b0, 1'b0, fc_exp(3 + i)));
        dv     = 1'b1;
        par_en = 1'b0;
        wait_frames(5);
        dv = 1'b0;
        check("b2b_gap_2", 32'(gap_of[gap_of.size()-2]), 32'd1);
        check("b2b_gap_3", 32'(gap_of[gap_of.size()-1]), 32'd1);
        tick(3);
        check("b2b_stopped", 32'(busy), 32'd0);

        // Watchdog: serializer never reports done.
        sd_normal = 1'b0;
        exp_q.push_back(mk_exp(DW + 1, 1'b0, 1'b1, fc_exp(5)));
        pulse_dv(1'b0);
        wait_frames(6);
        tick(2);
        check("wd_err_sticky", 32'(err), 32'd1);
        check("wd_frame_cnt", 32'(frame_cnt), 32'(fc_exp(5)));
        sd_normal = 1'b1;

        // Next accept clears err.
        exp_q.push_back(mk_exp(DW, 1'b0, 1'b0, fc_exp(6)));
        pulse_dv(1'b0);
        check("err_cleared_on_accept", 32'(err), 32'd0);
        check("start_mux", 32'(mux_sel), 32'd0);
        wait_frames(7);
        tick(2);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
